// File: rtl/i2c_target_mem_if.sv
// Bus-side signals of the I2C target memory: oversampled SCL/SDA levels in,
// open-drain SDA drive and write-cycle status out.
interface i2c_target_mem_if;
    logic scl_i;
    logic sda_i;
    logic sda_o;
    logic sda_oen_o;
    logic busy_o;

    modport slave  (input  scl_i, sda_i, output sda_o, sda_oen_o, busy_o);
    modport master (output scl_i, sda_i, input  sda_o, sda_oen_o, busy_o);
endinterface

// File: rtl/i2c_target_mem.sv
// I2C target with a byte-addressed memory, page-buffered writes and a timed
// internal write cycle. Optional write protect input: define I2C_TARGET_MEM_WP_EN.
module i2c_target_mem #(
    parameter int          MEM_AW    = 13,
    parameter int          PTR_BYTES = 2,
    parameter int          PAGE_SIZE = 32,
    parameter int          WR_CYCLES = 50000,
    parameter logic [3:0]  DEV_HI    = 4'b1010
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [2:0]       a_i,
`ifdef I2C_TARGET_MEM_WP_EN
    input  logic             wp_i,
`endif
    i2c_target_mem_if.slave  bus
);

    localparam int                PG_W      = (PAGE_SIZE > 1) ? $clog2(PAGE_SIZE) : 1;
    localparam int                BUF_N     = 1 << PG_W;
    localparam int                DEPTH     = 1 << MEM_AW;
    localparam int                CW        = $clog2(WR_CYCLES + 1);
    localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'(PAGE_SIZE - 1);
    localparam logic [PG_W-1:0]   PAGE_LAST = PG_W'(PAGE_SIZE - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV, S_DEV_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WACK, S_RDATA, S_RACK
    } state_t;

    logic wp_on;
`ifdef I2C_TARGET_MEM_WP_EN
    assign wp_on = wp_i;
`else
    assign wp_on = 1'b0;
`endif

    // ---------------- bus synchronisers and event detection ----------------
    logic [1:0] scl_sync_reg, sda_sync_reg;
    logic       scl_d_reg, sda_d_reg;
    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_sync_reg <= 2'b11;
            sda_sync_reg <= 2'b11;
            scl_d_reg    <= 1'b1;
            sda_d_reg    <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[0], bus.scl_i};
            sda_sync_reg <= {sda_sync_reg[0], bus.sda_i};
            scl_d_reg    <= scl_sync_reg[1];
            sda_d_reg    <= sda_sync_reg[1];
        end
    end

    assign scl_s     = scl_sync_reg[1];
    assign sda_s     = sda_sync_reg[1];
    assign scl_rise  = scl_s & ~scl_d_reg;
    assign scl_fall  = ~scl_s & scl_d_reg;
    assign start_det = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
    assign stop_det  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;

    // ---------------- protocol FSM ----------------
    state_t              state_reg, state_next;
    logic [3:0]          bit_cnt_reg, bit_cnt_next;
    logic [7:0]          shift_reg, shift_next;
    logic [MEM_AW-1:0]   ptr_reg, ptr_next;
    logic [1:0]          ptr_idx_reg, ptr_idx_next;
    logic                rw_reg, rw_next;
    logic                mack_reg, mack_next;
    logic                sda_reg, sda_next;
    logic                have_data_reg, have_data_next;
    logic                buf_we, buf_clr, commit_go;
    logic                busy_reg;
    logic [7:0]          rd_data_reg;
    logic [PG_W-1:0]     buf_idx;
    logic [7:0]          shift_in;

    assign shift_in = {shift_reg[6:0], sda_s};
    assign buf_idx  = PG_W'(ptr_reg & PAGE_MASK);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg     <= S_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            ptr_reg       <= '0;
            ptr_idx_reg   <= '0;
            rw_reg        <= 1'b0;
            mack_reg      <= 1'b1;
            sda_reg       <= 1'b1;
            have_data_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            ptr_reg       <= ptr_next;
            ptr_idx_reg   <= ptr_idx_next;
            rw_reg        <= rw_next;
            mack_reg      <= mack_next;
            sda_reg       <= sda_next;
            have_data_reg <= have_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        ptr_next       = ptr_reg;
        ptr_idx_next   = ptr_idx_reg;
        rw_next        = rw_reg;
        mack_next      = mack_reg;
        sda_next       = sda_reg;
        have_data_next = have_data_reg;
        buf_we         = 1'b0;
        buf_clr        = 1'b0;
        commit_go      = 1'b0;

        if (start_det) begin
            state_next     = S_DEV;
            bit_cnt_next   = '0;
            sda_next       = 1'b1;
            have_data_next = 1'b0;
            // The buffer is still being committed while busy; keep it intact.
            buf_clr        = ~busy_reg;
        end else if (stop_det) begin
            state_next     = S_IDLE;
            sda_next       = 1'b1;
            have_data_next = 1'b0;
            commit_go      = have_data_reg & ~wp_on;
        end else begin
            unique case (state_reg)
                S_DEV, S_PTR, S_WDATA: begin
                    if (scl_rise && bit_cnt_reg < 4'd8) begin
                        shift_next   = shift_in;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                        bit_cnt_next = '0;
                        if (state_reg == S_DEV) begin
                            if (shift_reg[7:1] == {DEV_HI, a_i} && !busy_reg) begin
                                state_next = S_DEV_ACK;
                                rw_next    = shift_reg[0];
                                sda_next   = 1'b0;
                            end else begin
                                state_next = S_IDLE;
                                sda_next   = 1'b1;
                            end
                        end else if (state_reg == S_PTR) begin
                            // Big-endian: each new byte shifts the previous ones up.
                            ptr_next     = MEM_AW'({ptr_reg, shift_reg});
                            ptr_idx_next = ptr_idx_reg + 2'd1;
                            state_next   = S_PTR_ACK;
                            sda_next     = 1'b0;
                        end else begin
                            buf_we         = 1'b1;
                            have_data_next = 1'b1;
                            ptr_next       = (ptr_reg & ~PAGE_MASK) | ((ptr_reg + 1'b1) & PAGE_MASK);
                            state_next     = S_WACK;
                            sda_next       = 1'b0;
                        end
                    end
                end
                S_DEV_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_next = '0;
                        if (rw_reg) begin
                            state_next = S_RDATA;
                            sda_next   = rd_data_reg[7];
                        end else begin
                            state_next   = S_PTR;
                            ptr_idx_next = '0;
                            sda_next     = 1'b1;
                        end
                    end
                end
                S_PTR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_next = '0;
                        sda_next     = 1'b1;
                        state_next   = (ptr_idx_reg == 2'(PTR_BYTES)) ? S_WDATA : S_PTR;
                    end
                end
                S_WACK: begin
                    if (scl_fall) begin
                        bit_cnt_next = '0;
                        sda_next     = 1'b1;
                        state_next   = S_WDATA;
                    end
                end
                S_RDATA: begin
                    if (scl_rise && bit_cnt_reg < 4'd8) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            state_next = S_RACK;
                            sda_next   = 1'b1;
                            ptr_next   = ptr_reg + 1'b1;
                        end else begin
                            sda_next = rd_data_reg[~bit_cnt_reg[2:0]];
                        end
                    end
                end
                S_RACK: begin
                    if (scl_rise) begin
                        mack_next = sda_s;
                    end else if (scl_fall) begin
                        bit_cnt_next = '0;
                        if (!mack_reg) begin
                            state_next = S_RDATA;
                            sda_next   = rd_data_reg[7];
                        end else begin
                            state_next = S_IDLE;
                            sda_next   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_o     = sda_reg;
    assign bus.sda_oen_o = sda_reg;

    // ---------------- page buffer ----------------
    logic [7:0]       page_buf [BUF_N];
    logic [BUF_N-1:0] valid_vec;

    always_ff @(posedge PCLK) begin
        if (buf_we) page_buf[buf_idx] <= shift_reg;
    end

    for (genvar gi = 0; gi < BUF_N; gi++) begin : g_valid
        logic v_reg;
        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn)                               v_reg <= 1'b0;
            else if (buf_clr)                           v_reg <= 1'b0;
            else if (buf_we && buf_idx == PG_W'(gi))    v_reg <= 1'b1;
        end
        assign valid_vec[gi] = v_reg;
    end

    // ---------------- write cycle timer and commit sequencer ----------------
    logic [CW-1:0]   busy_cnt_reg;
    logic            commit_active_reg;
    logic [PG_W-1:0] commit_idx_reg;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            busy_reg          <= 1'b0;
            busy_cnt_reg      <= '0;
            commit_active_reg <= 1'b0;
            commit_idx_reg    <= '0;
        end else if (commit_go) begin
            busy_reg          <= 1'b1;
            busy_cnt_reg      <= CW'(WR_CYCLES - 1);
            commit_active_reg <= 1'b1;
            commit_idx_reg    <= '0;
        end else begin
            if (busy_reg) begin
                if (busy_cnt_reg == '0) busy_reg <= 1'b0;
                else                    busy_cnt_reg <= busy_cnt_reg - 1'b1;
            end
            if (commit_active_reg) begin
                if (commit_idx_reg == PAGE_LAST) commit_active_reg <= 1'b0;
                commit_idx_reg <= commit_idx_reg + 1'b1;
            end
        end
    end

    assign bus.busy_o = busy_reg;

    // ---------------- memory array: one commit write port, one registered read ----------------
    logic [7:0]        mem [DEPTH];
    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;

    assign mem_we    = commit_active_reg & valid_vec[commit_idx_reg];
    assign mem_waddr = (ptr_reg & ~PAGE_MASK) | (MEM_AW'(commit_idx_reg) & PAGE_MASK);

    always_ff @(posedge PCLK) begin
        if (mem_we) mem[mem_waddr] <= page_buf[commit_idx_reg];
        rd_data_reg <= mem[ptr_reg];
    end

endmodule

// File: tb/tb_i2c_target_mem.sv
// Directed bench for i2c_target_mem: bit-banged I2C master, table-driven byte
// vectors and hand-written sequences for busy, paging, wrap and reset cases.
module tb_i2c_target_mem;
    localparam int WRC = 300;

    logic       PCLK    = 1'b0;
    logic       PRESETn = 1'b0;
    logic [2:0] a_i     = 3'b101;
    logic       m_scl   = 1'b1;
    logic       m_sda   = 1'b1;
`ifdef I2C_TARGET_MEM_WP_EN
    logic       wp_i    = 1'b0;
`endif

    i2c_target_mem_if bus();
    assign bus.scl_i = m_scl;
    assign bus.sda_i = m_sda & (bus.sda_oen_o | bus.sda_o);

    i2c_target_mem #(.WR_CYCLES(WRC)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .a_i     (a_i),
`ifdef I2C_TARGET_MEM_WP_EN
        .wp_i    (wp_i),
`endif
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;
    int busy_cyc    = 0;
    int oen_low_cyc = 0;

    always @(negedge PCLK) begin
        if (bus.busy_o)     busy_cyc    = busy_cyc + 1;
        if (!bus.sda_oen_o) oen_low_cyc = oen_low_cyc + 1;
    end

    typedef struct { logic [7:0] data; logic ack; } wvec_t;
    typedef struct { logic [15:0] ptr; logic [7:0] exp; } rvec_t;
    wvec_t wv [6];
    rvec_t rv [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
    endtask

    task automatic i2c_bit(input logic b, output logic r);
        tick(2); m_sda = b;
        tick(4); m_scl = 1'b1;
        tick(3); @(negedge PCLK); r = bus.sda_i;
        tick(3); m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(6);
        m_scl = 1'b1; tick(6);
        m_sda = 1'b0; tick(6);
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(6);
        m_scl = 1'b1; tick(6);
        m_sda = 1'b1; tick(6);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
        i2c_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            d[i] = r;
        end
        i2c_bit(nack, r);
    endtask

    // START, device write address, pointer bytes; ok=1 when all three ACKed.
    task automatic set_ptr(input logic [15:0] p, output logic ok);
        logic a0, a1, a2;
        i2c_start();
        wr_byte(8'hAA, a0);
        wr_byte(p[15:8], a1);
        wr_byte(p[7:0], a2);
        ok = a0 & a1 & a2;
    endtask

    task automatic rd_at(input logic [15:0] p, output logic ok, output logic [7:0] d);
        logic o1, a;
        set_ptr(p, o1);
        i2c_start();
        wr_byte(8'hAB, a);
        rd_byte(1'b1, d);
        i2c_stop();
        ok = o1 & a;
    endtask

    task automatic wait_busy_done(input string name);
        for (int n = 0; n < 100 && !bus.busy_o; n++) @(negedge PCLK);
        check({name, "_busy_rise"}, bus.busy_o, 1'b1);
        for (int n = 0; n < WRC + 100 && bus.busy_o; n++) @(negedge PCLK);
        check({name, "_busy_fall"}, bus.busy_o, 1'b0);
    endtask

    initial begin
        logic       ack, ok;
        logic [7:0] d;
        int         b0, o0, nacks;

        wv[0] = '{8'hAA, 1'b1};
        wv[1] = '{8'h00, 1'b1};
        wv[2] = '{8'h00, 1'b1};
        wv[3] = '{8'h10, 1'b1};
        wv[4] = '{8'h20, 1'b1};
        wv[5] = '{8'h30, 1'b1};
        rv[0] = '{16'h001E, 8'h20};
        rv[1] = '{16'h001F, 8'h21};
        rv[2] = '{16'h0000, 8'h02};
        rv[3] = '{16'h0001, 8'h03};
        rv[4] = '{16'h001D, 8'h1F};

        // reset state
        tick(4);
        @(negedge PCLK);
        check("rst_sda_o", bus.sda_o, 1'b1);
        check("rst_sda_oen", bus.sda_oen_o, 1'b1);
        check("rst_busy", bus.busy_o, 1'b0);
        PRESETn = 1'b1;
        tick(4);

        // 3-byte page write; NACK while busy; exact busy length
        i2c_start();
        for (int i = 0; i < 6; i++) begin
            wr_byte(wv[i].data, ack);
            check($sformatf("wr_ack%0d", i), ack, wv[i].ack);
        end
        b0 = busy_cyc;
        i2c_stop();
        for (int n = 0; n < 100 && !bus.busy_o; n++) @(negedge PCLK);
        check("busy_rise", bus.busy_o, 1'b1);
        i2c_start();
        wr_byte(8'hAA, ack);
        check("nack_while_busy", ack, 1'b0);
        i2c_stop();
        check("still_busy", bus.busy_o, 1'b1);
        for (int n = 0; n < WRC + 100 && bus.busy_o; n++) @(negedge PCLK);
        check("busy_len", busy_cyc - b0, WRC);
        i2c_start();
        wr_byte(8'hAA, ack);
        check("ack_after_busy", ack, 1'b1);
        i2c_stop();
        tick(30);
        check("no_busy_addr_only", bus.busy_o, 1'b0);

        // pointer write pointer only, then repeated START sequential read
        o0 = busy_cyc;
        set_ptr(16'h0000, ok);
        check("rd_ptr_ack", ok, 1'b1);
        i2c_start();
        wr_byte(8'hAB, ack);
        check("rd_dev_ack", ack, 1'b1);
        rd_byte(1'b0, d); check("rd0", d, 8'h10);
        rd_byte(1'b0, d); check("rd1", d, 8'h20);
        rd_byte(1'b1, d); check("rd2", d, 8'h30);
        tick(4);
        check("rd_release", bus.sda_oen_o, 1'b1);
        i2c_stop();
        tick(20);
        check("no_busy_ptr_only", busy_cyc - o0, 0);

        // 34 bytes into a 32-byte page starting at 0x1E
        set_ptr(16'h001E, ok);
        check("page_ptr_ack", ok, 1'b1);
        nacks = 0;
        for (int k = 0; k < 34; k++) begin
            wr_byte(8'(k), ack);
            if (!ack) nacks++;
        end
        check("page_nacks", nacks, 0);
        i2c_stop();
        wait_busy_done("page");
        for (int i = 0; i < 5; i++) begin
            rd_at(rv[i].ptr, ok, d);
            check($sformatf("page_rd_ack%0d", i), ok, 1'b1);
            check($sformatf("page_rd%0d", i), d, rv[i].exp);
        end

        // read pointer wraps from the top of memory to 0
        set_ptr(16'h1FFF, ok);
        wr_byte(8'h5A, ack);
        check("top_wr_ack", ok & ack, 1'b1);
        i2c_stop();
        wait_busy_done("top");
        set_ptr(16'h1FFF, ok);
        i2c_start();
        wr_byte(8'hAB, ack);
        rd_byte(1'b0, d); check("wrap_rd0", d, 8'h5A);
        rd_byte(1'b1, d); check("wrap_rd1", d, 8'h02);
        i2c_stop();

        // wrong device address: NACK and SDA left alone until next START
        o0 = oen_low_cyc;
        i2c_start();
        wr_byte(8'hA0, ack);
        check("wrong_addr_nack", ack, 1'b0);
        wr_byte(8'h00, ack);
        wr_byte(8'hFF, ack);
        check("wrong_addr_quiet", oen_low_cyc - o0, 0);
        i2c_start();
        wr_byte(8'hAA, ack);
        check("next_start_ack", ack, 1'b1);
        i2c_stop();

`ifdef I2C_TARGET_MEM_WP_EN
        set_ptr(16'h0100, ok);
        wr_byte(8'h11, ack);
        i2c_stop();
        wait_busy_done("wp_pre");
        wp_i = 1'b1;
        b0 = busy_cyc;
        set_ptr(16'h0100, ok);
        wr_byte(8'hAA, ack);
        check("wp_ack", ok & ack, 1'b1);
        i2c_stop();
        tick(50);
        check("wp_no_busy", busy_cyc - b0, 0);
        wp_i = 1'b0;
        rd_at(16'h0100, ok, d);
        check("wp_readback", d, 8'h11);
`endif

        // asynchronous reset while the device-address ACK is driven
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            logic r;
            d = 8'hAA;
            i2c_bit(d[i], r);
        end
        tick(6);
        check("ack_driven", bus.sda_oen_o, 1'b0);
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        check("rst_mid_oen", bus.sda_oen_o, 1'b1);
        check("rst_mid_sda", bus.sda_o, 1'b1);
        tick(3);
        PRESETn = 1'b1;
        i2c_stop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_target_mem.md
I2C_TARGET_MEM -- requirements
Module: i2c_target_mem

Interface
REQ-001 Parameter MEM_AW, default 13: memory byte-address width; depth = 2^MEM_AW bytes.
REQ-002 Parameter PTR_BYTES, default 2: pointer bytes after the device address; legal values 1 or 2; pointer = low MEM_AW bits, big-endian.
REQ-003 Parameter PAGE_SIZE, default 32: write-page bytes, power of two, at most 2^MEM_AW.
REQ-004 Parameter WR_CYCLES, default 50000: internal write-cycle length in PCLK cycles (5 ms at 10 MHz).
REQ-005 Parameter DEV_HI, default 4'b1010: upper 4 bits of the 7-bit device address.
REQ-006 PCLK  in  1  sole clock; SCL/SDA are oversampled on it.
REQ-007 PRESETn  in  1  asynchronous, active-low reset.
REQ-008 a_i  in  3  device-address bits [2:0] (A2,A1,A0).
REQ-009 scl_i  in  1  bus SCL level.
REQ-010 sda_i  in  1  bus SDA level.
REQ-011 sda_o  out  1  0 pulls SDA low, 1 releases.
REQ-012 sda_oen_o  out  1  active-low drive enable; 0 exactly when sda_o=0.
REQ-013 busy_o  out  1  high during the internal write cycle.

Function
REQ-014 scl_i/sda_i pass through 2-flop synchronisers; all decoding uses synchronised levels and their 1-cycle edge pulses.
REQ-015 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both are honoured in every state and abort any transfer.
REQ-016 States: IDLE, DEV, DEV_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK; START -> DEV from any state; STOP -> IDLE.
REQ-017 Bits are sampled MSB first on synchronised SCL rising; SDA outputs change only in the PCLK cycle after synchronised SCL falling.
REQ-018 DEV: 8 bits; match = {DEV_HI,a_i}; no match or busy_o=1 -> release SDA (NACK), go IDLE until next START.
REQ-019 Match, R/W=0 -> ACK, PTR; PTR_BYTES bytes each ACKed, loading the pointer; then WDATA.
REQ-020 Match, R/W=1 -> ACK, RDATA at the current pointer (random read via repeated START after PTR).
REQ-021 WDATA: each byte ACKed, stored into a PAGE_SIZE page buffer at pointer low bits; only those bits increment, wrapping within the page.
REQ-022 STOP after at least one data byte: buffered bytes commit to memory, busy_o rises next cycle for exactly WR_CYCLES cycles; STOP after pointer only: no write, no busy.
REQ-023 RDATA: drive mem[pointer] MSB first; pointer increments after each byte, wrapping at 2^MEM_AW; master ACK -> next byte, master NACK -> IDLE (SDA released).
REQ-024 More than PAGE_SIZE bytes in one write overwrite earlier buffer entries; last value per location wins.
REQ-025 START during busy_o: device-address byte NACKed; busy counter unaffected.

Reset
REQ-026 PRESETn low, asynchronously: state IDLE, sda_o=1, sda_oen_o=1, busy_o=0, busy counter 0, pointer 0, page buffer discarded; memory array not reset.
REQ-027 Reset mid-transfer or mid-write-cycle: uncommitted data lost, SDA released within the same cycle.

Configuration
REQ-028 Macro I2C_TARGET_MEM_WP_EN defined: extra input wp_i (1 bit); wp_i=1 sampled at STOP -> data bytes still ACKed, no commit, no busy_o.
REQ-029 Macro undefined: wp_i port absent, writes never inhibited.

Verification
REQ-030 a_i=3'b101, write 0x55/W, ptr 0x00,0x00, data 0x10,0x20,0x30, STOP -> all 6 bytes ACKed, busy_o high exactly 50000 cycles.
REQ-031 Address 0x55 sent while busy_o=1 -> NACK; after busy_o falls -> ACK.
REQ-032 Write ptr 0x0000, repeated START, 0x55/R, 3 bytes, NACK last -> reads 0x10,0x20,0x30, SDA released after final byte.
REQ-033 Write 34 bytes 0x00..0x21 at ptr 0x001E -> mem[0x1E]=0x20, mem[0x1F]=0x21, mem[0x00]=0x02.
REQ-034 Address 0x50/W with a_i=3'b101 -> NACK, sda_oen_o stays 1 until next START.
REQ-035 I2C_TARGET_MEM_WP_EN defined, wp_i=1, write 0xAA at ptr 0x0100 -> bytes ACKed, busy_o stays 0, readback unchanged.
